rr_sel_arbiter: RTL
===================

Name: rr_sel_arbiter

Overview:
- Round-robin arbiter that sits directly upstream of the team's 4:1 select mux.
- Takes four request lines and decides which source owns the shared path.
- Drives the mux's 2-bit select with a registered, glitch-free index, held stable for the whole grant.
- Grants are held until the owner signals done, drops its request, or a hold timeout expires.

Parameters:
- NREQ, 4, number of requesters. Fixed at 4 to match the mux; other values are unsupported.
- SEL_W, 2, select width, equal to log2(NREQ).
- MAX_HOLD, 8, maximum grant length in cycles before a forced release. Legal range 2..255.

Ports:
- iClk, input, 1, single clock; all state updates on the rising edge.
- iRst, input, 1, synchronous active-high reset.
- iEn, input, 1, arbitration enable. Low blocks new grants; a current grant runs to release.
- iReq, input, 4, request lines; bit n requests mux input n.
- iDone, input, 1, the current owner has finished. Sampled only while a grant is active.
- oS, output, 2, select index to the mux. Registered.
- oGntValid, output, 1, a grant is active and oS is meaningful.
- oGnt, output, 4, one-hot grant. Equals 1<<oS when oGntValid is 1, else 0.
- oTimeout, output, 1, one-cycle pulse when a grant was ended by MAX_HOLD.

Behaviour:
- Reset (iRst high at an edge):
  - State IDLE, oS=0, oGntValid=0, oGnt=0, oTimeout=0.
  - Rotate pointer ptr=0, hold counter cnt=0.
  - Reset mid-grant aborts the grant at that edge; no timeout pulse is produced.
- Pick function (combinational):
  - Scan iReq starting at index ptr, upward, wrapping modulo 4.
  - The first set bit wins.
  - No set bit means no pick.
- State IDLE:
  - If iEn=1 and a pick exists at edge t, then from t+1: state GRANT, oS=pick, oGntValid=1, cnt=0.
  - Request-to-grant latency is 1 cycle.
- State GRANT: oS is frozen. A release condition at edge t is any of:
  - iDone=1
  - iReq[oS]=0
  - cnt==MAX_HOLD-1
- Otherwise, in GRANT: cnt increments by 1 each cycle. cnt saturates and never wraps.
- On release at edge t:
  - ptr becomes oS+1 mod 4 (wraps 3->0), so the old owner is lowest priority.
  - Re-arbitration uses the new ptr and iReq as sampled at edge t, with iReq[old owner] included.
  - If iEn=1 and a pick exists: back-to-back grant. oS=new pick, oGntValid stays 1, cnt=0. There is no idle bubble.
  - Otherwise: IDLE with oGntValid=0. oS keeps its last value (don't-care for the mux).
- oTimeout:
  - Asserts for exactly the cycle after a release caused solely by cnt==MAX_HOLD-1.
  - If iDone or a request drop coincides with the timeout, the release is a normal release and oTimeout stays 0.
- Single requester held continuously:
  - Re-granted to itself after each timeout or done, with no bubble.
  - oTimeout pulses every MAX_HOLD cycles.
- iEn deasserted during GRANT: the grant continues; at release the block goes to IDLE.
- Requests are level-sensitive. Requests from non-owners never disturb the current grant.
- ptr changes only on release. It does not change while idle.

Decomposition:
- Shared package `arb_pkg`:
  - State enum {IDLE, GRANT}.
  - Constants NREQ=4 and SEL_W=2.
  - Type for the select index.
- One sub-module `rr_pick`: purely combinational.
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: found, idx[1:0].
  - Instantiated once and used for both the IDLE and release arbitration paths.

Test Plan:
- Reset, then iEn=1, iReq=0101 from cycle 1 -> from cycle 2, oS=0, oGnt=0001, oGntValid=1.
- Owner 0 pulses iDone in cycle 4 with iReq=0101 still held -> cycle 5: oS=2, oGnt=0100, no bubble; ptr becomes 1.
- iReq=1000 held, iDone=0, MAX_HOLD=8 -> oS=3 for 8 cycles, then oTimeout=1 for one cycle while oS=3 is re-granted; repeats every 8 cycles.
- Grant on 3 with iReq=1001, then iReq[3] drops -> next cycle oS=0 (ptr wrapped 3->0); no oTimeout.
- iDone and timeout in the same cycle -> release occurs, oTimeout=0. Also: iEn=0 during a grant -> grant continues, then IDLE with oGntValid=0 and oGnt=0000 after release.
- iRst=1 mid-grant with oS=2 -> next cycle all outputs 0 and ptr=0; with iReq=0110, the first grant after reset is oS=1.

Source files
------------

// File: rtl/rr_sel_arbiter_pkg.sv
// Shared types and constants for the round-robin select arbiter and its picker.
package arb_pkg;

  localparam int NREQ  = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  typedef logic [SEL_W-1:0] sel_t;
  typedef logic [NREQ-1:0]  req_t;

  function automatic req_t sel_onehot(input sel_t s);
    req_t v;
    v = '0;
    v[s] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_sel_arbiter_if.sv
// Request/grant bundle between the requesters and the arbiter, plus FSM debug taps.
interface rr_sel_arbiter_if;
  import arb_pkg::*;

  // Handshake: requests are level-sensitive; a grant is valid while oGntValid is high,
  // and the owner ends it with iDone or by dropping its request line.
  logic   iEn;
  logic   [NREQ-1:0] iReq;
  logic   iDone;
  sel_t   oS;
  logic   oGntValid;
  logic   [NREQ-1:0] oGnt;
  logic   oTimeout;
  state_e dbg_state;
  sel_t   dbg_ptr;

  modport master (
    output iEn, iReq, iDone,
    input  oS, oGntValid, oGnt, oTimeout, dbg_state, dbg_ptr
  );

  modport slave (
    input  iEn, iReq, iDone,
    output oS, oGntValid, oGnt, oTimeout, dbg_state, dbg_ptr
  );

endinterface

// File: rtl/rr_sel_arbiter_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick
  import arb_pkg::*;
(
  input  req_t req,
  input  sel_t ptr,
  output logic found,
  output sel_t idx
);

  sel_t cand;

  // Scan from the farthest offset down so the nearest-to-ptr hit is written last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = ptr + sel_t'(i);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_sel_arbiter.sv
// Round-robin arbiter driving a registered 2-bit select into a 4:1 mux, with hold timeout.
module rr_sel_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input logic             iClk,
  input logic             iRst,
  rr_sel_arbiter_if.slave bus
);

  localparam logic [7:0] CNT_LAST = 8'(MAX_HOLD - 1);
  localparam logic [7:0] CNT_MAX  = 8'hFF;

  state_e     state_q, state_n;
  sel_t       sel_q, sel_n;
  sel_t       ptr_q, ptr_n;
  logic [7:0] cnt_q, cnt_n;
  logic       timeout_q, timeout_n;

  sel_t pick_ptr;
  logic pick_found;
  sel_t pick_idx;
  logic rel_done, rel_drop, rel_to, rel_any;

  // While granting, the picker already looks from owner+1 so a release can re-grant at once.
  always_comb begin
    pick_ptr = ptr_q;
    if (state_q == GRANT) begin
      pick_ptr = sel_q + sel_t'(1);
    end
  end

  rr_pick u_pick (
    .req   (bus.iReq),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    rel_done = bus.iDone;
    rel_drop = !bus.iReq[sel_q];
    rel_to   = (cnt_q == CNT_LAST);
    rel_any  = rel_done || rel_drop || rel_to;
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_n;
      sel_q     <= sel_n;
      ptr_q     <= ptr_n;
      cnt_q     <= cnt_n;
      timeout_q <= timeout_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    sel_n     = sel_q;
    ptr_n     = ptr_q;
    cnt_n     = cnt_q;
    timeout_n = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.iEn && pick_found) begin
          state_n = GRANT;
          sel_n   = pick_idx;
          cnt_n   = '0;
        end
      end
      GRANT: begin
        if (rel_any) begin
          ptr_n     = sel_q + sel_t'(1);
          // Only a pure hold expiry is flagged; a coinciding done or drop is a normal release.
          timeout_n = rel_to && !rel_done && !rel_drop;
          cnt_n     = '0;
          if (bus.iEn && pick_found) begin
            sel_n = pick_idx;
          end else begin
            state_n = IDLE;
          end
        end else if (cnt_q != CNT_MAX) begin
          cnt_n = cnt_q + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    bus.oS        = sel_q;
    bus.oGntValid = (state_q == GRANT);
    bus.oGnt      = (state_q == GRANT) ? sel_onehot(sel_q) : '0;
    bus.oTimeout  = timeout_q;
    bus.dbg_state = state_q;
    bus.dbg_ptr   = ptr_q;
  end

endmodule
